// File: rtl/sauce_timer_arbiter.sv
// Round-robin shared seconds-countdown timer for the Flag Vending Machine.
// One requester at a time owns the timer; completion is signalled with a one-cycle done pulse.
module sauce_timer_arbiter #(
   parameter int N_REQ   = 4,
   parameter int CLK_DIV = 20000000,
   parameter int SEC_W   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*SEC_W-1:0] req_secs,
   output logic [N_REQ-1:0]       grant,
   output logic [N_REQ-1:0]       done,
   output logic                   busy,
   output logic [SEC_W-1:0]       remaining,
   output logic                   tick_1hz
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int PRE_W = $clog2(CLK_DIV + 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [PRE_W-1:0] presc, presc_nxt;
   logic [IDX_W-1:0] ptr, ptr_nxt;
   logic [IDX_W-1:0] own, own_nxt;
   logic [N_REQ-1:0] grant_nxt, done_nxt;
   logic             busy_nxt, tick_nxt;
   logic [SEC_W-1:0] rem_nxt;
   logic             win_vld;
   logic [IDX_W-1:0] win_idx;
   logic [SEC_W-1:0] win_secs;
   logic             tick_due;

   function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off);
      int s;
      s = base + off;
      if (s >= N_REQ) s = s - N_REQ;
      return IDX_W'(s);
   endfunction

   function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
      logic [N_REQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Search from the pointer upward; iterating backwards lets the nearest requester win.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[wrap_idx(int'(ptr), k)]) begin
            win_vld = 1'b1;
            win_idx = wrap_idx(int'(ptr), k);
         end
      end
   end

   assign win_secs = req_secs[int'(win_idx)*SEC_W +: SEC_W];
   assign tick_due = (presc == PRE_LAST);

   always_comb begin
      state_nxt = state;
      presc_nxt = presc;
      ptr_nxt   = ptr;
      own_nxt   = own;
      grant_nxt = grant;
      done_nxt  = '0;
      busy_nxt  = busy;
      rem_nxt   = remaining;
      tick_nxt  = 1'b0;
      case (state)
         IDLE: begin
            presc_nxt = '0;
            rem_nxt   = '0;
            if (win_vld) begin
               grant_nxt = onehot(win_idx);
               own_nxt   = win_idx;
               busy_nxt  = 1'b1;
               rem_nxt   = win_secs;
               ptr_nxt   = (win_idx == IDX_LAST) ? '0 : win_idx + IDX_W'(1);
               if (win_secs != '0) begin
                  state_nxt = RUN;
               end else begin
                  state_nxt = DONE;
                  done_nxt  = onehot(win_idx);
               end
            end
         end
         RUN: begin
            // Owner withdrawal beats a coincident tick: no done is ever issued on abort.
            if (!req[own]) begin
               grant_nxt = '0;
               busy_nxt  = 1'b0;
               rem_nxt   = '0;
               presc_nxt = '0;
               state_nxt = IDLE;
            end else begin
               presc_nxt = tick_due ? '0 : presc + PRE_W'(1);
               if (tick_due) begin
                  tick_nxt = 1'b1;
                  rem_nxt  = (remaining != '0) ? remaining - SEC_W'(1) : '0;
                  if (remaining == SEC_W'(1)) begin
                     done_nxt  = onehot(own);
                     state_nxt = DONE;
                  end
               end
            end
         end
         DONE: begin
            grant_nxt = '0;
            busy_nxt  = 1'b0;
            rem_nxt   = '0;
            presc_nxt = '0;
            state_nxt = IDLE;
         end
         default: begin
            grant_nxt = '0;
            busy_nxt  = 1'b0;
            rem_nxt   = '0;
            presc_nxt = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         presc     <= '0;
         ptr       <= '0;
         own       <= '0;
         grant     <= '0;
         done      <= '0;
         busy      <= 1'b0;
         remaining <= '0;
         tick_1hz  <= 1'b0;
      end else begin
         state     <= state_nxt;
         presc     <= presc_nxt;
         ptr       <= ptr_nxt;
         own       <= own_nxt;
         grant     <= grant_nxt;
         done      <= done_nxt;
         busy      <= busy_nxt;
         remaining <= rem_nxt;
         tick_1hz  <= tick_nxt;
      end
   end

endmodule
